// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and default width for the bit-serial subtractor
package serial_sub_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit combinational full adder used as a serial datapath slice
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b behind a start/done handshake
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  sub_state_t       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, res_sr_q, diff_q, res_d;
  logic             carry_q, carry_d, sum, b_inv, last;
  logic             a_msb_q, b_msb_q, busy_q, done_q, borrow_q, ovf_q;
  assign b_inv = ~b_sr_q[0];
  full_adder u_fa (
    .a   (a_sr_q[0]),
    .b   (b_inv),
    .cin (carry_q),
    .sum (sum),
    .cout(carry_d)
  );
  assign res_d      = {sum, res_sr_q[WIDTH-1:1]};
  assign last       = cnt_q == CW'(WIDTH - 1);
  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;
  // Control FSM and serial datapath; results latch only on the final shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_sr_q  <= a;
          b_sr_q  <= b;
          a_msb_q <= a[WIDTH-1];
          b_msb_q <= b[WIDTH-1];
          carry_q <= 1'b1;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= SHIFT;
        end
        SHIFT: begin
          res_sr_q <= res_d;
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          carry_q  <= carry_d;
          cnt_q    <= cnt_q + CW'(1);
          if (last) begin
            diff_q   <= res_d;
            borrow_q <= ~carry_d;
            ovf_q    <= (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench for serial_subtractor
module tb_serial_subtractor;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, borrow_out, overflow;
  logic [W-1:0] diff;
  int checks = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff),
    .borrow_out(borrow_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, diff, borrow_out, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b diff=%h borrow=%b ovf=%b, want all 0",
               busy, done, diff, borrow_out, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_release: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    int n, bc;
    @(negedge clk);
    start = 1'b1; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = 'x; b = 'x;
    n = 1; bc = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== W + 1) begin
      failures++;
      $display("FAIL %s_latency: got %0d edges, want %0d", name, n, W + 1);
    end
    checks++;
    if (bc !== W) begin
      failures++;
      $display("FAIL %s_busy_cycles: got %0d, want %0d", name, bc, W);
    end
    checks++;
    if (diff !== ed) begin
      failures++;
      $display("FAIL %s_diff: got %h, want %h", name, diff, ed);
    end
    checks++;
    if (borrow_out !== eb) begin
      failures++;
      $display("FAIL %s_borrow: got %b, want %b", name, borrow_out, eb);
    end
    checks++;
    if (overflow !== eo) begin
      failures++;
      $display("FAIL %s_overflow: got %b, want %b", name, overflow, eo);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_in_done: got %b, want 0", name, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || diff !== ed) begin
      failures++;
      $display("FAIL %s_done_pulse: got done=%b diff=%h, want done=0 diff=%h", name, done, diff, ed);
    end
  endtask

  task automatic test_basic();
    run_op("basic", 8'd100, 8'd37, 8'h3F, 1'b0, 1'b0);
  endtask

  task automatic test_flags();
    run_op("borrow", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
    run_op("ovf_neg", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("zero", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("ovf_pos", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
  endtask

  task automatic test_ignored_start();
    int dones, unstable;
    logic [W-1:0] prev;
    prev = diff;
    dones = 0; unstable = 0;
    @(negedge clk);
    start = 1'b1; a = 8'h55; b = 8'h11;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2 * W + 6; i++) begin
      if (i == 2) begin start = 1'b1; a = 8'hFF; b = 8'h01; end
      else start = 1'b0;
      if (busy && diff !== prev) unstable++;
      if (done) begin
        dones++;
        checks++;
        if (diff !== 8'h44 || borrow_out !== 1'b0 || overflow !== 1'b0) begin
          failures++;
          $display("FAIL ignored_result: got diff=%h b=%b o=%b, want 44 0 0", diff, borrow_out, overflow);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (dones !== 1) begin
      failures++;
      $display("FAIL ignored_done_count: got %0d, want 1", dones);
    end
    checks++;
    if (unstable !== 0) begin
      failures++;
      $display("FAIL ignored_diff_stable: got %0d changes while busy, want 0", unstable);
    end
  endtask

  task automatic test_reset_mid_op();
    int dones;
    dones = 0;
    @(negedge clk);
    start = 1'b1; a = 8'h30; b = 8'h10;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, diff, borrow_out, overflow} !== '0) begin
      failures++;
      $display("FAIL async_reset: got busy=%b done=%b diff=%h borrow=%b ovf=%b, want all 0",
               busy, done, diff, borrow_out, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL reset_no_done: got %0d busy/done cycles, want 0", dones);
    end
    run_op("after_reset", 8'hC8, 8'h64, 8'h64, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    start = 1'b1; a = 8'h05; b = 8'h03;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (diff !== 8'h02) begin
      failures++;
      $display("FAIL b2b_first_diff: got %h, want 02", diff);
    end
    start = 1'b1; a = 8'h03; b = 8'h05;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_start_in_done: got busy=%b, want 0", busy);
    end
    @(negedge clk);
    start = 1'b0;
    n = 2;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== W + 2) begin
      failures++;
      $display("FAIL b2b_spacing: got %0d edges between dones, want %0d", n, W + 2);
    end
    checks++;
    if (diff !== 8'hFE || borrow_out !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: got diff=%h b=%b o=%b, want FE 1 0", diff, borrow_out, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flags();
    test_ignored_start();
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor that computes diff = a - b one bit per clock, LSB first. It is the inverse companion to the team's combinational full_adder cell, which it reuses as its datapath slice. It serves as an area-cheap arithmetic unit behind a start/done handshake for control paths where latency is not critical.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
start  input  1  request pulse; sampled only in IDLE
a  input  WIDTH  minuend; captured on the accepted start edge
b  input  WIDTH  subtrahend; captured on the accepted start edge
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse; results valid in this cycle
diff  output  WIDTH  a - b modulo 2^WIDTH
borrow_out  output  1  unsigned borrow (a < b unsigned)
overflow  output  1  signed overflow of a - b

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset (async assert, sync release): state=IDLE; busy, done, diff, borrow_out, overflow, counter, carry and shift registers all 0.
- States:
  - IDLE: start=1 at edge k → load a_sr=a, b_sr=b, carry=1, cnt=0, and go to SHIFT.
  - SHIFT: each cycle, the full_adder computes (a_sr[0], ~b_sr[0], carry). At the edge, the sum shifts into the MSB of the internal res_sr, a_sr and b_sr shift right, carry takes the new cout, and cnt increments.
  - SHIFT exit: when cnt==WIDTH-1, the edge moves to DONE. On the same edge it latches diff=final res_sr, borrow_out=~final carry, and overflow=(a_msb!=b_msb)&&(diff_msb!=a_msb), using the captured operand MSBs.
  - DONE: lasts one cycle, then returns unconditionally to IDLE.
- busy=1 exactly in SHIFT, i.e. WIDTH cycles after edge k.
- done=1 exactly in DONE, i.e. the cycle after edge k+WIDTH. Latency from start sample to done is WIDTH+1 edges.
- diff, borrow_out and overflow are updated only on SHIFT→DONE. They hold stable until the next completion; intermediate bits are never visible.
- start while busy or in DONE: ignored, with no queuing. a and b are don't-care outside the accepted start edge.
- Back-to-back operation: the earliest next start is accepted in the IDLE cycle after done. Throughput is one op per WIDTH+2 cycles.
- Reset mid-operation: the operation is aborted, no done is issued, and all outputs clear to 0.
- Counter width is $clog2(WIDTH). No wrap is possible because the counter resets on each load.

Decomposition:
- Package serial_sub_pkg holds:
  - typedef enum {IDLE, SHIFT, DONE} sub_state_t, 2 bits;
  - localparam DEFAULT_WIDTH=8.
- Sub-module: one instance of the existing full_adder cell (a, b, cin → sum, cout) as the per-bit slice. The inversion of b and the carry-in=1 initialisation live in serial_subtractor.

Test Plan:
- WIDTH=8, a=100, b=37, start 1 cycle → busy for 8 cycles; done exactly 9 edges after start; diff=8'h3F, borrow_out=0, overflow=0.
- a=8'h10, b=8'h20 → diff=8'hF0, borrow_out=1, overflow=0. Then a=8'h80, b=8'h01 → diff=8'h7F, borrow_out=0, overflow=1.
- a=0, b=0 → diff=0, borrow_out=0, overflow=0. Then a=8'h7F, b=8'hFF → diff=8'h80, borrow_out=1, overflow=1.
- Pulse start again with different operands 3 cycles into an op → ignored; only one done is issued, diff reflects the first operands, and the previous diff stays stable while busy.
- Assert rst during SHIFT cycle 4, asynchronously between edges → busy and all outputs 0 immediately, no done follows. A new start after release yields correct results.
- Back-to-back: start in the IDLE cycle right after done → accepted; second done follows exactly WIDTH+1 edges later.
